load_store_unit: RTL

- Sits between the RV32I datapath's ALU/register-file outputs and the data-memory port.
- Converts a core load/store request (address, funct3, store data) into a word-aligned memory transaction:
  - byte enables and lane-replicated store data on the way out;
  - lane extraction and sign/zero extension of load data on the way back.
- Stalls the core while the transaction is in flight; works with zero-wait-state and variable-latency memories.
- Flags misaligned accesses, illegal funct3 and memory timeouts.

---
 rtl/load_store_unit_if.sv | 37 +++
 rtl/load_store_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Data-memory port of the load/store unit.
// master: LSU (MemReq/Addr/We/Be/WrData out); slave: memory (MemGnt/Rvalid/Rdata out).
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  MemReq;
  logic                  MemGnt;
  logic [ADDR_WIDTH-1:0] MemAddr;
  logic                  MemWe;
  logic [3:0]            MemBe;
  logic [DATA_WIDTH-1:0] MemWrData;
  logic                  MemRvalid;
  logic [DATA_WIDTH-1:0] MemRdata;

  modport master (
    output MemReq,
    output MemAddr,
    output MemWe,
    output MemBe,
    output MemWrData,
    input  MemGnt,
    input  MemRvalid,
    input  MemRdata
  );

  modport slave (
    input  MemReq,
    input  MemAddr,
    input  MemWe,
    input  MemBe,
    input  MemWrData,
    output MemGnt,
    output MemRvalid,
    output MemRdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: core request -> word-aligned memory access.
// Ports: clk, Reset (sync, high); Lsu* core side (req/we/funct3/addr/wrdata
// in; stall/done/err/rddata out); mem = load_store_unit_if.master bus.
module load_store_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  LsuReq,
  input  logic                  LsuWe,
  input  logic [2:0]            LsuFunct3,
  input  logic [ADDR_WIDTH-1:0] LsuAddr,
  input  logic [DATA_WIDTH-1:0] LsuWrData,
  output logic                  LsuStall,
  output logic                  LsuDone,
  output logic                  LsuErr,
  output logic [DATA_WIDTH-1:0] LsuRdData,
  load_store_unit_if.master     mem
);

  generate
    if (DATA_WIDTH != 32) begin : g_bad_width
      $error("load_store_unit: only DATA_WIDTH=32 is supported");
    end
  endgenerate

  // Wide enough to hold TIMEOUT_CYCLES+1 without wrapping.
  localparam int            CW     = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);
  localparam bit            TO_EN  = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          to_hit;
  logic [1:0]    lane;
  logic [2:0]    f3;

  logic                  is_b;
  logic                  is_h;
  logic                  is_w;
  logic                  bad_f3;
  logic                  misal;
  logic [3:0]            be_new;
  logic [DATA_WIDTH-1:0] wd_new;

  logic [7:0]            ld_b;
  logic [15:0]           ld_h;
  logic [DATA_WIDTH-1:0] ld_ext;

  assign LsuStall = LsuReq & ~LsuDone;

  assign cnt_next = cnt + CW'(1);
  assign to_hit   = TO_EN && (cnt_next >= TO_LIM);

  always_comb begin
    is_b   = (LsuFunct3[1:0] == 2'b00);
    is_h   = (LsuFunct3[1:0] == 2'b01);
    is_w   = (LsuFunct3[1:0] == 2'b10);
    // Loads allow unsigned byte/half; stores have no funct3[2] forms.
    bad_f3 = (LsuFunct3[1:0] == 2'b11) |
             (LsuWe ? LsuFunct3[2] : (LsuFunct3[2] & LsuFunct3[1]));
    misal  = (is_h & LsuAddr[0]) | (is_w & (|LsuAddr[1:0]));
    be_new = 4'b1111;
    wd_new = LsuWrData;
    unique case (1'b1)
      is_b: begin
        be_new = 4'b0001 << LsuAddr[1:0];
        wd_new = {4{LsuWrData[7:0]}};
      end
      is_h: begin
        be_new = 4'b0011 << {LsuAddr[1], 1'b0};
        wd_new = {2{LsuWrData[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_b = mem.MemRdata[7:0];
    unique case (lane)
      2'd0: ld_b = mem.MemRdata[7:0];
      2'd1: ld_b = mem.MemRdata[15:8];
      2'd2: ld_b = mem.MemRdata[23:16];
      2'd3: ld_b = mem.MemRdata[31:24];
      default: ;
    endcase
    ld_h   = lane[1] ? mem.MemRdata[31:16] : mem.MemRdata[15:0];
    ld_ext = mem.MemRdata;
    // funct3[2] set means zero-extend (LBU/LHU).
    unique case (1'b1)
      (f3[1:0] == 2'b00): ld_ext = {{24{ld_b[7] & ~f3[2]}}, ld_b};
      (f3[1:0] == 2'b01): ld_ext = {{16{ld_h[15] & ~f3[2]}}, ld_h};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state         <= IDLE;
      cnt           <= '0;
      lane          <= '0;
      f3            <= '0;
      LsuDone       <= 1'b0;
      LsuErr        <= 1'b0;
      LsuRdData     <= '0;
      mem.MemReq    <= 1'b0;
      mem.MemAddr   <= '0;
      mem.MemWe     <= 1'b0;
      mem.MemBe     <= '0;
      mem.MemWrData <= '0;
    end else begin
      LsuDone <= 1'b0;
      LsuErr  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (LsuReq) begin
            lane          <= LsuAddr[1:0];
            f3            <= LsuFunct3;
            mem.MemAddr   <= {LsuAddr[ADDR_WIDTH-1:2], 2'b00};
            mem.MemWe     <= LsuWe;
            mem.MemBe     <= be_new;
            mem.MemWrData <= wd_new;
            if (bad_f3 | misal) begin
              state   <= DONE;
              LsuDone <= 1'b1;
              LsuErr  <= 1'b1;
            end else begin
              state      <= REQ;
              mem.MemReq <= 1'b1;
              cnt        <= '0;
            end
          end
        end
        REQ: begin
          cnt <= cnt_next;
          // A grant in the timeout cycle still completes the access.
          if (mem.MemGnt) begin
            mem.MemReq <= 1'b0;
            if (mem.MemWe) begin
              state   <= DONE;
              LsuDone <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end else if (to_hit) begin
            mem.MemReq <= 1'b0;
            state      <= DONE;
            LsuDone    <= 1'b1;
            LsuErr     <= 1'b1;
          end
        end
        WAIT: begin
          cnt <= cnt_next;
          if (mem.MemRvalid) begin
            LsuRdData <= ld_ext;
            state     <= DONE;
            LsuDone   <= 1'b1;
          end else if (to_hit) begin
            state   <= DONE;
            LsuDone <= 1'b1;
            LsuErr  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
